// File: rtl/tx_word_pkg.sv
// Shared UART constants for the host link (transmit and receive paths),
// plus the bit-FSM state type and a byte-select helper.
package tx_word_pkg;

  // Baud divisors at a 12 MHz clock (clk cycles per bit, truncated).
  localparam int B9600   = 1250;
  localparam int B19200  = 625;
  localparam int B57600  = 208;
  localparam int B115200 = 104;
  localparam int B230400 = 52;

  // 8N1 frame layout.
  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } bit_state_t;

  // Byte idx of a word, byte 0 being the least significant.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 byte transmitter: START/DATA/STOP bit FSM with a baud counter.
// done is high in the last cycle of a stop bit so the caller can chain the
// next byte's start bit with no idle gap.
module uart_tx_byte
  import tx_word_pkg::*;
#(
  parameter int BAUD_DIV = B115200
) (
  input  logic       clk12,
  input  logic       rstn,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  bit_state_t        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [2:0]        next_bit;
  logic              baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign next_bit  = bit_cnt + 3'd1;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_STOP) && baud_last;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // tx is registered so the line never sees combinational glitches.
  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_START;
            baud_cnt <= '0;
            tx       <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            state    <= S_DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= byte_in[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= next_bit;
              tx      <= byte_in[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            // A start request here chains the next byte back-to-back.
            if (start) begin
              state <= S_START;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/tx_word.sv
// Sends a 32-bit word to the host as four 8N1 bytes, LSB first, behind a
// valid/ready handshake; word_sent pulses as the final stop bit ends.
module tx_word
  import tx_word_pkg::*;
#(
  parameter int BAUD_DIV = B115200
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic [31:0] word,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        word_sent
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] hold;
  logic [1:0]  byte_index;
  logic        go;
  logic        accept;
  logic        byte_start;
  logic        byte_busy;
  logic        byte_done;
  logic [7:0]  cur_byte;

  assign accept     = word_valid && word_ready;
  assign cur_byte   = word_byte(hold, byte_index);
  // First byte launches from the registered go; later bytes chain off done.
  assign byte_start = (go && !byte_busy) || (byte_done && (byte_index != LAST_BYTE));

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      hold       <= '0;
      byte_index <= '0;
      go         <= 1'b0;
      word_ready <= 1'b1;
      word_sent  <= 1'b0;
    end else begin
      go        <= 1'b0;
      word_sent <= 1'b0;
      if (accept) begin
        hold       <= word;
        byte_index <= '0;
        go         <= 1'b1;
        word_ready <= 1'b0;
      end
      if (byte_done) begin
        if (byte_index == LAST_BYTE) begin
          byte_index <= '0;
          word_sent  <= 1'b1;
          word_ready <= 1'b1;
        end else begin
          byte_index <= byte_index + 2'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx_byte (
    .clk12  (clk12),
    .rstn   (rstn),
    .byte_in(cur_byte),
    .start  (byte_start),
    .busy   (byte_busy),
    .done   (byte_done),
    .tx     (tx)
  );

endmodule
